mux_nto1_pipe: RTL and testbench

Parametrised, registered N-to-1 word selector. It is the pipelined successor to the combinational 64-to-1 8-bit selector.
- Selects one DATA_W-bit word from a flattened NUM_CH-word bus (vault), driven by a per-request select or by an internal round-robin scan pointer.
- Result is held in an output register behind a valid/ready handshake.
- Sits between register-bank/vault storage and downstream consumers that may stall.

---
 rtl/mux_pkg.sv | 17 +
 rtl/mux_nto1_pipe_scan_ptr_ctr.sv | 41 ++++
 rtl/mux_nto1_pipe.sv | 126 ++++++++++++
 tb/tb_mux_nto1_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined N-to-1 word selector.
// Optional feature macro: MUX_PARITY_EN (adds out_parity on the top).
package mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Index width for n entries, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_nto1_pipe_scan_ptr_ctr.sv
// Round-robin scan pointer for mux_nto1_pipe: counts 0..NUM_CH-1 and wraps.
// cur_ptr is the value to use this cycle: clr forces it to zero immediately,
// and an enable in the same cycle advances from that zero.
module scan_ptr_ctr
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 64,
  localparam int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] cur_ptr
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] nxt;

  assign cur_ptr = clr ? '0 : ptr;

  // Next pointer: advance with wrap when enabled, else keep the effective value.
  always_comb begin
    nxt = cur_ptr;
    if (en) begin
      nxt = (cur_ptr == LAST) ? '0 : cur_ptr + SEL_W'(1);
    end
  end

  // Pointer register; only moves on clear or advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr || en) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 word selector with valid/ready output handshake.
// Direct mode picks vault[req_sel]; scan mode walks an internal pointer.
// Optional feature macro: MUX_PARITY_EN (adds out_parity = ^treasure).
module mux_nto1_pipe
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 64,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [NUM_CH*DATA_W-1:0] vault,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SEL_W-1:0]         req_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        treasure,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_last,
  output logic                     sel_err
`ifdef MUX_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  mode_e            mode_cur;
  mode_e            mode_q;
  logic             scan;
  logic             scan_edge;
  logic             accept;
  logic [SEL_W-1:0] scan_idx;
  logic [SEL_W-1:0] idx;
  logic             oor;
  logic             last_hit;
  logic [DATA_W-1:0] word;

  assign mode_cur  = mode_e'(mode);
  assign scan      = (mode_cur == MODE_SCAN);
  assign scan_edge = scan && (mode_q == MODE_DIRECT);
  assign req_ready = !out_valid || out_ready;
  assign accept    = req_valid && req_ready;

  scan_ptr_ctr #(
    .NUM_CH (NUM_CH)
  ) u_scan_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (scan_edge),
    .en      (accept && scan),
    .cur_ptr (scan_idx)
  );

  // Index actually used for this cycle's request.
  always_comb begin
    idx = req_sel;
    if (scan) begin
      idx = scan_idx;
    end
  end

  // A power-of-two channel count cannot be addressed out of range.
  if (NUM_CH == (1 << SEL_W)) begin : g_full_range
    assign oor = 1'b0;
  end else begin : g_part_range
    assign oor = !scan && (req_sel >= SEL_W'(NUM_CH));
  end

  assign last_hit = scan && (idx == SEL_W'(NUM_CH - 1));

  // Word mux; an out-of-range index matches nothing and yields zero.
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (idx == SEL_W'(k)) begin
        word = vault[k*DATA_W +: DATA_W];
      end
    end
    if (oor) begin
      word = '0;
    end
  end

  // Mode history for detecting the direct-to-scan transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_DIRECT;
    end else begin
      mode_q <= mode_cur;
    end
  end

  // Output register: load on accept, drop valid on drain, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      treasure  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      sel_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      treasure  <= word;
      out_sel   <= idx;
      out_last  <= last_hit;
      sel_err   <= oor;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_PARITY_EN
  // Parity registered alongside treasure; zero word gives zero parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (accept) begin
      out_parity <= ^word;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench for mux_nto1_pipe: a 64x8 and a 5x8 instance, both
// compared every cycle against a beat-level reference model.
// Optional feature macro: MUX_PARITY_EN (checks out_parity when defined).
module tb_mux_nto1_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 64-channel instance
  logic         a_mode, a_req_valid, a_out_ready;
  logic [511:0] a_vault;
  logic [5:0]   a_req_sel;
  logic         a_req_ready, a_out_valid, a_out_last, a_sel_err;
  logic [7:0]   a_treasure;
  logic [5:0]   a_out_sel;
  // 5-channel instance
  logic         b_mode, b_req_valid, b_out_ready;
  logic [39:0]  b_vault;
  logic [2:0]   b_req_sel;
  logic         b_req_ready, b_out_valid, b_out_last, b_sel_err;
  logic [7:0]   b_treasure;
  logic [2:0]   b_out_sel;
`ifdef MUX_PARITY_EN
  logic         a_out_parity, b_out_parity;
`endif

  mux_nto1_pipe #(.NUM_CH(64), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .vault(a_vault),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_sel(a_req_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .treasure(a_treasure),
    .out_sel(a_out_sel), .out_last(a_out_last), .sel_err(a_sel_err)
`ifdef MUX_PARITY_EN
    , .out_parity(a_out_parity)
`endif
  );

  mux_nto1_pipe #(.NUM_CH(5), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .vault(b_vault),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_sel(b_req_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .treasure(b_treasure),
    .out_sel(b_out_sel), .out_last(b_out_last), .sel_err(b_sel_err)
`ifdef MUX_PARITY_EN
    , .out_parity(b_out_parity)
`endif
  );

  // Reference model: the beat currently presented plus scan bookkeeping.
  typedef struct {
    bit         v;
    logic [7:0] t;
    int         sel;
    bit         last;
    bit         err;
    int         ptr;
    bit         mq;
  } mstate_t;

  mstate_t ma, mb;
  int checks = 0;
  int errors = 0;

  function automatic mstate_t step(mstate_t s, int n, bit md, logic [511:0] vault,
                                   bit rv, int rsel, bit ordy);
    mstate_t r;
    int      p;
    int      i;
    r = s;
    p = (md && !s.mq) ? 0 : s.ptr;
    r.mq  = md;
    r.ptr = p;
    if (rv && (!s.v || ordy)) begin
      i      = md ? p : rsel;
      r.v    = 1'b1;
      r.sel  = i;
      r.err  = !md && (i >= n);
      r.t    = r.err ? 8'h00 : vault[i*8 +: 8];
      r.last = md && (i == n - 1);
      if (md) r.ptr = (p + 1) % n;
    end else if (ordy) begin
      r.v = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
    end else begin
      ma <= step(ma, 64, a_mode, a_vault, a_req_valid, int'(a_req_sel), a_out_ready);
      mb <= step(mb, 5, b_mode, 512'(b_vault), b_req_valid, int'(b_req_sel), b_out_ready);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_valid",    32'(a_out_valid), 32'(ma.v));
    chk("a_treasure", 32'(a_treasure),  32'(ma.t));
    chk("a_sel",      32'(a_out_sel),   32'(ma.sel));
    chk("a_last",     32'(a_out_last),  32'(ma.last));
    chk("a_err",      32'(a_sel_err),   32'(ma.err));
    chk("a_ready",    32'(a_req_ready), 32'(!ma.v || a_out_ready));
    chk("b_valid",    32'(b_out_valid), 32'(mb.v));
    chk("b_treasure", 32'(b_treasure),  32'(mb.t));
    chk("b_sel",      32'(b_out_sel),   32'(mb.sel));
    chk("b_last",     32'(b_out_last),  32'(mb.last));
    chk("b_err",      32'(b_sel_err),   32'(mb.err));
    chk("b_ready",    32'(b_req_ready), 32'(!mb.v || b_out_ready));
`ifdef MUX_PARITY_EN
    chk("a_parity",   32'(a_out_parity), 32'(^ma.t));
    chk("b_parity",   32'(b_out_parity), 32'(^mb.t));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_vaults();
    for (int k = 0; k < 16; k++) a_vault[k*32 +: 32] = $urandom;
    b_vault = {8'($urandom), 32'($urandom)};
  endtask

  initial begin
    rst_n = 1'b0;
    a_mode = 1'b0; a_req_valid = 1'b0; a_out_ready = 1'b0; a_req_sel = '0;
    b_mode = 1'b0; b_req_valid = 1'b0; b_out_ready = 1'b0; b_req_sel = '0;
    for (int k = 0; k < 64; k++) a_vault[k*8 +: 8] = 8'(k + 'hA0);
    for (int k = 0; k < 5; k++)  b_vault[k*8 +: 8] = 8'(k + 'hA0);
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_a_valid",    32'(a_out_valid), 32'd0);
    chk("rst_a_treasure", 32'(a_treasure),  32'd0);
    chk("rst_b_sel",      32'(b_out_sel),   32'd0);
    chk("rst_b_err",      32'(b_sel_err),   32'd0);
    rst_n = 1'b1;

    // Direct select of word 5
    a_req_valid = 1'b1; a_req_sel = 6'd5; a_out_ready = 1'b1;
    tick();
    chk("dir_treasure", 32'(a_treasure), 32'hA5);
    chk("dir_sel",      32'(a_out_sel),  32'd5);
    chk("dir_err",      32'(a_sel_err),  32'd0);
    chk("dir_valid",    32'(a_out_valid), 32'd1);

    // Stall holds the beat regardless of vault and req_sel changes
    a_req_sel = 6'd3;
    tick();
    chk("stall_first", 32'(a_treasure), 32'hA3);
    a_out_ready = 1'b0; a_req_sel = 6'd9;
    repeat (4) begin
      rand_vaults();
      tick();
      chk("stall_hold",  32'(a_treasure),  32'hA3);
      chk("stall_ready", 32'(a_req_ready), 32'd0);
    end
    a_out_ready = 1'b1;
    #1 chk("release_ready", 32'(a_req_ready), 32'd1);
    tick();
    chk("release_sel",   32'(a_out_sel),   32'd9);
    chk("release_valid", 32'(a_out_valid), 32'd1);
    a_req_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(a_out_valid), 32'd0);
    chk("drain_sel",   32'(a_out_sel),   32'd9);

    // Scan run on the 5-channel instance
    for (int k = 0; k < 5; k++) b_vault[k*8 +: 8] = 8'(k + 'hA0);
    b_mode = 1'b1; b_req_valid = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("scan_sel",  32'(b_out_sel),  32'(i % 5));
      chk("scan_last", 32'(b_out_last), 32'((i % 5) == 4));
    end
    repeat (2) tick();
    chk("scan_pre_switch", 32'(b_out_sel), 32'd2);

    // Leave scan with pointer at 3, then re-enter: restart at word 0
    b_mode = 1'b0; b_req_sel = 3'd2;
    tick();
    chk("direct_last", 32'(b_out_last), 32'd0);
    b_mode = 1'b1;
    tick();
    chk("mode_edge_sel", 32'(b_out_sel), 32'd0);

    // Out-of-range direct select
    b_mode = 1'b0; b_req_sel = 3'd6;
    tick();
    chk("oor_treasure", 32'(b_treasure), 32'd0);
    chk("oor_err",      32'(b_sel_err),  32'd1);
    chk("oor_sel",      32'(b_out_sel),  32'd6);
    b_req_sel = 3'd2;
    tick();
    chk("inrange_err",      32'(b_sel_err),  32'd0);
    chk("inrange_treasure", 32'(b_treasure), 32'hA2);

    // Random traffic on both instances
    repeat (400) begin
      rand_vaults();
      if ($urandom_range(0, 9) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 9) == 0) b_mode = ~b_mode;
      a_req_valid = 1'($urandom_range(0, 3) != 0);
      b_req_valid = 1'($urandom_range(0, 3) != 0);
      a_out_ready = 1'($urandom_range(0, 2) != 0);
      b_out_ready = 1'($urandom_range(0, 2) != 0);
      a_req_sel   = 6'($urandom);
      b_req_sel   = 3'($urandom);
      tick();
    end

    // Parity word, then async reset while stalled
    a_mode = 1'b0; a_req_valid = 1'b1; a_out_ready = 1'b1; a_req_sel = 6'd0;
    a_vault[7:0] = 8'h07;
    b_req_valid = 1'b1; b_out_ready = 1'b1;
    tick();
    chk("par_treasure", 32'(a_treasure), 32'h07);
`ifdef MUX_PARITY_EN
    chk("par_bit", 32'(a_out_parity), 32'd1);
`endif
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a_valid",    32'(a_out_valid), 32'd0);
    chk("arst_b_valid",    32'(b_out_valid), 32'd0);
    chk("arst_a_treasure", 32'(a_treasure),  32'd0);
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b_mode = 1'b1; b_req_valid = 1'b1; b_out_ready = 1'b1;
    tick();
    chk("post_rst_scan_sel", 32'(b_out_sel), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
